bus_arbiter: RTL and testbench

//  Two-master arbiter in front of the system bridge (DM / TC0 / TC1 address decode).
//  M0 = CPU data port, M1 = secondary master (DMA / debug loader).

---
 rtl/bus_arbiter_pkg.sv | 37 +++
 rtl/bus_arbiter_arb_grant.sv | 47 ++++
 rtl/bus_arbiter.sv | 133 +++++++++++++
 tb/tb_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arbiter_pkg;

  // Arbiter FSM states: IDLE -> ACCESS -> RESP -> IDLE
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  // Master identifiers; M0 is the CPU data port, M1 the secondary master.
  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } master_id_t;

  // Default bus wait window (cycles) before read data is sampled.
  localparam int unsigned WAIT_CYC_DEF   = 1;
  // Default cap on consecutive M0 grants while M1 is waiting.
  localparam int unsigned M0_MAX_RUN_DEF = 4;
  // Width of the wait and run counters; both parameters are limited to 1..15.
  localparam int unsigned CNT_W          = 4;

  // Latched copy of the winning master's request.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    master_id_t  id;
  } req_latch_t;

  // A request is a write when any byte enable is set.
  function automatic logic is_write(input logic [3:0] byteen);
    return |byteen;
  endfunction

endpackage

// File: rtl/bus_arbiter_arb_grant.sv
// Winner selection with M0 priority and an anti-starvation run counter for M1.
module arb_grant
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned M0_MAX_RUN = M0_MAX_RUN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_m0_req,
  input  logic       i_m1_req,
  input  logic       i_grant_en,
  output master_id_t o_winner
);

  localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(M0_MAX_RUN);

  logic [CNT_W-1:0] r_run_cnt;
  logic             w_cap_hit;
  master_id_t       w_winner;

  // Once M0 has used up its run while M1 waits, M1 wins the next contest.
  assign w_cap_hit = (r_run_cnt == MAX_RUN);

  // Winner: a lone requester wins; on contention M0 wins unless the cap is hit.
  always_comb begin
    w_winner = MST_M0;
    if (i_m1_req && (!i_m0_req || w_cap_hit)) begin
      w_winner = MST_M1;
    end
  end

  // Run counter: counts M0 grants made against a waiting M1, cleared by any M1 grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_run_cnt <= '0;
    end else if (i_grant_en) begin
      if (w_winner == MST_M1) begin
        r_run_cnt <= '0;
      end else if (i_m1_req && !w_cap_hit) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
    end
  end

  assign o_winner = w_winner;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: latches one request, drives the bridge for a fixed
// wait window, samples read data and returns a single-cycle ack to the owner.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYC   = WAIT_CYC_DEF,
  parameter int unsigned M0_MAX_RUN = M0_MAX_RUN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_byteen,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_byteen,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYC);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [CNT_W-1:0] r_wait_cnt;
  req_latch_t       r_req;
  logic [31:0]      r_rdata;

  logic             w_any_req;
  logic             w_grant_en;
  logic             w_first_access;
  logic             w_last_access;
  master_id_t       w_winner;
  req_latch_t       w_win_req;
  logic             w_ack       [2];
  logic [31:0]      w_rdata_out [2];

  assign w_any_req      = m0_req | m1_req;
  assign w_grant_en     = (r_state == ARB_IDLE) && w_any_req;
  // The wait counter is loaded with WAIT_CYC at grant and counts down to 1.
  assign w_first_access = (r_state == ARB_ACCESS) && (r_wait_cnt == WAIT_LOAD);
  assign w_last_access  = (r_state == ARB_ACCESS) && (r_wait_cnt == CNT_W'(1));

  arb_grant #(
    .M0_MAX_RUN (M0_MAX_RUN)
  ) u_arb_grant (
    .clk        (clk),
    .reset      (reset),
    .i_m0_req   (m0_req),
    .i_m1_req   (m1_req),
    .i_grant_en (w_grant_en),
    .o_winner   (w_winner)
  );

  // Select the winning master's request fields for latching.
  always_comb begin
    w_win_req.addr   = m0_addr;
    w_win_req.byteen = m0_byteen;
    w_win_req.wdata  = m0_wdata;
    w_win_req.id     = MST_M0;
    if (w_winner == MST_M1) begin
      w_win_req.addr   = m1_addr;
      w_win_req.byteen = m1_byteen;
      w_win_req.wdata  = m1_wdata;
      w_win_req.id     = MST_M1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE:   if (w_any_req) w_state_next = ARB_ACCESS;
      ARB_ACCESS: if (w_last_access) w_state_next = ARB_RESP;
      ARB_RESP:   w_state_next = ARB_IDLE;
      default:    w_state_next = ARB_IDLE;
    endcase
  end

  // Request latch, wait counter and read-data capture on the last ACCESS edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req      <= '0;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
    end else if (w_grant_en) begin
      r_req      <= w_win_req;
      r_wait_cnt <= WAIT_LOAD;
    end else if (r_state == ARB_ACCESS) begin
      r_wait_cnt <= r_wait_cnt - 1'b1;
      if (w_last_access) begin
        r_rdata <= is_write(r_req.byteen) ? 32'h0 : bus_rdata;
      end
    end
  end

  // Bridge outputs: address/data held for the whole window, write strobe only
  // in the first cycle so that side-effecting registers see a single write.
  assign bus_addr   = (r_state == ARB_ACCESS) ? r_req.addr  : 32'h0;
  assign bus_wdata  = (r_state == ARB_ACCESS) ? r_req.wdata : 32'h0;
  assign bus_byteen = w_first_access ? r_req.byteen : 4'h0;
  assign busy       = (r_state != ARB_IDLE);

  // Per-master response: ack and read data only for the owner, during RESP.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign w_ack[gi]       = (r_state == ARB_RESP) && (r_req.id == master_id_t'(gi));
    assign w_rdata_out[gi] = w_ack[gi] ? r_rdata : 32'h0;
  end

  assign m0_ack   = w_ack[0];
  assign m0_rdata = w_rdata_out[0];
  assign m1_ack   = w_ack[1];
  assign m1_rdata = w_rdata_out[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: one DUT with WAIT_CYC=1, one with WAIT_CYC=3.
module tb_bus_arbiter;

  typedef struct {
    bit          id;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset1, reset3;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata;
  logic [3:0]  m0_byteen, m1_byteen;

  logic        a_m0_ack, a_m1_ack, a_busy;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wdata;
  logic [3:0]  a_bus_byteen;
  logic        b_m0_ack, b_m1_ack, b_busy;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_wdata;
  logic [3:0]  b_bus_byteen;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_arbiter #(.WAIT_CYC(1), .M0_MAX_RUN(4)) dut1 (
    .clk(clk), .reset(reset1),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_byteen(m0_byteen), .m0_wdata(m0_wdata),
    .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_byteen(m1_byteen), .m1_wdata(m1_wdata),
    .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .bus_addr(a_bus_addr), .bus_byteen(a_bus_byteen), .bus_wdata(a_bus_wdata),
    .bus_rdata(bus_rdata), .busy(a_busy)
  );

  bus_arbiter #(.WAIT_CYC(3), .M0_MAX_RUN(4)) dut3 (
    .clk(clk), .reset(reset3),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_byteen(m0_byteen), .m0_wdata(m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_byteen(m1_byteen), .m1_wdata(m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .bus_addr(b_bus_addr), .bus_byteen(b_bus_byteen), .bus_wdata(b_bus_wdata),
    .bus_rdata(bus_rdata), .busy(b_busy)
  );

  // Scoreboard for dut1: every ack pops one expected transaction.
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if ((!a_m0_ack && a_m0_rdata !== 32'h0) || (!a_m1_ack && a_m1_rdata !== 32'h0)) begin
        n_fail++;
        $display("FAIL dut1_rdata_idle cyc=%0d got m0=%h m1=%h, expected 0 without ack", cyc, a_m0_rdata, a_m1_rdata);
      end
      if (a_m0_ack || a_m1_ack) begin
        n_tests++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL dut1_unexpected_ack cyc=%0d got m0_ack=%b m1_ack=%b, expected none", cyc, a_m0_ack, a_m1_ack);
        end else begin
          e1 = q1.pop_front();
          $display("[TB] dut1 ack m%0d rdata=%h cyc=%0d", a_m1_ack, a_m1_ack ? a_m1_rdata : a_m0_rdata, cyc);
          if ((a_m0_ack && a_m1_ack) || a_m1_ack !== e1.id || cyc != e1.cyc ||
              (a_m1_ack ? a_m1_rdata : a_m0_rdata) !== e1.rdata) begin
            n_fail++;
            $display("FAIL dut1_txn got m0_ack=%b m1_ack=%b rdata=%h cyc=%0d, expected m%0d rdata=%h cyc=%0d",
                     a_m0_ack, a_m1_ack, a_m1_ack ? a_m1_rdata : a_m0_rdata, cyc, e1.id, e1.rdata, e1.cyc);
          end
        end
      end
    end
  end

  // Scoreboard for dut3 (WAIT_CYC=3).
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if ((!b_m0_ack && b_m0_rdata !== 32'h0) || (!b_m1_ack && b_m1_rdata !== 32'h0)) begin
        n_fail++;
        $display("FAIL dut3_rdata_idle cyc=%0d got m0=%h m1=%h, expected 0 without ack", cyc, b_m0_rdata, b_m1_rdata);
      end
      if (b_m0_ack || b_m1_ack) begin
        n_tests++;
        if (q3.size() == 0) begin
          n_fail++;
          $display("FAIL dut3_unexpected_ack cyc=%0d got m0_ack=%b m1_ack=%b, expected none", cyc, b_m0_ack, b_m1_ack);
        end else begin
          e3 = q3.pop_front();
          $display("[TB] dut3 ack m%0d rdata=%h cyc=%0d", b_m1_ack, b_m1_ack ? b_m1_rdata : b_m0_rdata, cyc);
          if ((b_m0_ack && b_m1_ack) || b_m1_ack !== e3.id || cyc != e3.cyc ||
              (b_m1_ack ? b_m1_rdata : b_m0_rdata) !== e3.rdata) begin
            n_fail++;
            $display("FAIL dut3_txn got m0_ack=%b m1_ack=%b rdata=%h cyc=%0d, expected m%0d rdata=%h cyc=%0d",
                     b_m0_ack, b_m1_ack, b_m1_ack ? b_m1_rdata : b_m0_rdata, cyc, e3.id, e3.rdata, e3.cyc);
          end
        end
      end
    end
  end

  task automatic test_reset;
    reset1 = 1'b0; reset3 = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_byteen = '0; m1_byteen = '0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({a_busy, a_m0_ack, a_m1_ack, b_busy} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl got busy/acks=%b, expected 0000", {a_busy, a_m0_ack, a_m1_ack, b_busy});
    end
    n_tests++;
    if (a_bus_byteen !== 4'h0 || a_bus_addr !== 32'h0 || a_bus_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus got addr=%h be=%h wd=%h, expected all 0", a_bus_addr, a_bus_byteen, a_bus_wdata);
    end
    n_tests++;
    if (a_m0_rdata !== 32'h0 || a_m1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h/%h, expected 0/0", a_m0_rdata, a_m1_rdata);
    end
    reset1 = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req got busy=%b, expected 0", a_busy);
    end
  endtask

  task automatic test_m0_read;
    int strobes = 0;
    int acks0 = 0;
    int acks1 = 0;
    bus_rdata = 32'h1234_5678;
    m0_addr = 32'h0000_0010; m0_byteen = 4'h0; m0_wdata = 32'hFFFF_FFFF; m0_req = 1'b1;
    q1.push_back('{1'b0, 32'h1234_5678, cyc + 2});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_bus_byteen !== 4'h0) strobes++;
      if (a_m1_ack) acks1++;
      if (i == 0) begin
        n_tests++;
        if (a_busy !== 1'b1 || a_bus_addr !== 32'h10) begin
          n_fail++; $display("FAIL m0_read_access got busy=%b addr=%h, expected 1/00000010", a_busy, a_bus_addr);
        end
      end
      if (a_m0_ack) begin acks0++; m0_req = 1'b0; end
    end
    n_tests++;
    if (strobes != 0) begin n_fail++; $display("FAIL m0_read_strobe got %0d strobe cycles, expected 0", strobes); end
    n_tests++;
    if (acks0 != 1 || acks1 != 0) begin n_fail++; $display("FAIL m0_read_acks got m0=%0d m1=%0d, expected 1/0", acks0, acks1); end
  endtask

  task automatic test_m1_write;
    int strobes = 0;
    int acks = 0;
    bus_rdata = 32'hDEAD_BEEF;
    m1_addr = 32'h0000_7F00; m1_byteen = 4'b1111; m1_wdata = 32'hA5A5_A5A5; m1_req = 1'b1;
    q1.push_back('{1'b1, 32'h0, cyc + 2});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_bus_byteen !== 4'h0) begin
        strobes++;
        n_tests++;
        if (a_bus_byteen !== 4'hF || a_bus_wdata !== 32'hA5A5_A5A5 || a_bus_addr !== 32'h7F00) begin
          n_fail++;
          $display("FAIL m1_write_bus got be=%h wd=%h addr=%h, expected F/a5a5a5a5/00007f00", a_bus_byteen, a_bus_wdata, a_bus_addr);
        end
      end
      if (a_m1_ack) begin acks++; m1_req = 1'b0; end
    end
    n_tests++;
    if (strobes != 1) begin n_fail++; $display("FAIL m1_write_strobe got %0d strobe cycles, expected 1", strobes); end
    n_tests++;
    if (acks != 1) begin n_fail++; $display("FAIL m1_write_acks got %0d, expected 1", acks); end
  endtask

  task automatic test_priority;
    int acks = 0;
    int m1_acks = 0;
    bit order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    reset1 = 1'b0;
    @(negedge clk);
    reset1 = 1'b1;
    bus_rdata = 32'h0BAD_F00D;
    m0_addr = 32'h100; m0_byteen = 4'h0; m1_addr = 32'h200; m1_byteen = 4'h0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 10; i++) q1.push_back('{order[i], 32'h0BAD_F00D, cyc + 2 + 3 * i});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_m0_ack || a_m1_ack) acks++;
      if (a_m1_ack) m1_acks++;
      if (acks == 10) begin m0_req = 1'b0; m1_req = 1'b0; break; end
    end
    n_tests++;
    if (acks != 10 || m1_acks != 2) begin
      n_fail++; $display("FAIL priority_counts got acks=%0d m1=%0d, expected 10/2", acks, m1_acks);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int acks = 0;
    m0_addr = 32'h300; m0_byteen = 4'b0011; m0_wdata = 32'h1122_3344; m0_req = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_busy !== 1'b1 || a_bus_byteen !== 4'b0011) begin
      n_fail++; $display("FAIL rst_mid_access got busy=%b be=%h, expected 1/3", a_busy, a_bus_byteen);
    end
    reset1 = 1'b0; m0_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_busy !== 1'b0 || a_bus_byteen !== 4'h0 || a_m0_ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_abort got busy=%b be=%h ack=%b, expected 0/0/0", a_busy, a_bus_byteen, a_m0_ack);
    end
    reset1 = 1'b1;
    repeat (3) @(negedge clk);
    bus_rdata = 32'hCAFE_F00D;
    m0_addr = 32'h20; m0_byteen = 4'h0; m0_req = 1'b1;
    q1.push_back('{1'b0, 32'hCAFE_F00D, cyc + 2});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_m0_ack) begin acks++; m0_req = 1'b0; end
    end
    n_tests++;
    if (acks != 1) begin n_fail++; $display("FAIL rst_mid_recover got %0d acks, expected 1", acks); end
  endtask

  task automatic test_wait3;
    int acks = 0;
    int strobes = 0;
    reset1 = 1'b0; reset3 = 1'b1;
    @(negedge clk);
    bus_rdata = 32'h1;
    m0_addr = 32'h40; m0_byteen = 4'h0; m0_req = 1'b1;
    q3.push_back('{1'b0, 32'h3, cyc + 4});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (b_busy !== 1'b1 || b_bus_addr !== 32'h40 || b_m0_ack !== 1'b0 || b_bus_byteen !== 4'h0) begin
        n_fail++;
        $display("FAIL wait3_access%0d got busy=%b addr=%h ack=%b be=%h, expected 1/00000040/0/0", i, b_busy, b_bus_addr, b_m0_ack, b_bus_byteen);
      end
      if (i == 0) m0_addr = 32'hFFFF_0000;
      bus_rdata = 32'(i + 1);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_m0_ack) begin acks++; m0_req = 1'b0; break; end
    end
    n_tests++;
    if (acks != 1) begin n_fail++; $display("FAIL wait3_read_ack got %0d acks, expected 1", acks); end
    @(negedge clk);
    acks = 0;
    bus_rdata = 32'h77;
    m1_addr = 32'h7F04; m1_byteen = 4'b1000; m1_wdata = 32'h5A5A_0000; m1_req = 1'b1;
    q3.push_back('{1'b1, 32'h0, cyc + 4});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_bus_byteen !== 4'h0) strobes++;
      if (b_m1_ack) begin acks++; m1_req = 1'b0; end
    end
    n_tests++;
    if (strobes != 1 || acks != 1) begin
      n_fail++; $display("FAIL wait3_write got strobes=%0d acks=%0d, expected 1/1", strobes, acks);
    end
    reset3 = 1'b0; reset1 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int acks = 0;
    int idle = 0;
    int first = 0;
    int last = 0;
    bus_rdata = 32'h55AA_55AA;
    m0_addr = 32'h80; m0_byteen = 4'h0; m0_req = 1'b1;
    for (int i = 0; i < 3; i++) q1.push_back('{1'b0, 32'h55AA_55AA, cyc + 2 + 3 * i});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acks >= 1 && acks < 3 && !a_busy) idle++;
      if (a_m0_ack) begin
        acks++;
        if (acks == 1) first = cyc;
        last = cyc;
        if (acks == 3) begin m0_req = 1'b0; break; end
      end
    end
    n_tests++;
    if (acks != 3 || last - first != 6) begin
      n_fail++; $display("FAIL b2b_spacing got acks=%0d span=%0d, expected 3/6", acks, last - first);
    end
    n_tests++;
    if (idle != 2) begin n_fail++; $display("FAIL b2b_idle got %0d idle cycles, expected 2", idle); end
    m0_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_m1_write();
    test_priority();
    test_reset_mid();
    test_wait3();
    test_back_to_back();
    n_tests++;
    if (q1.size() != 0 || q3.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got %0d/%0d pending, expected 0/0", q1.size(), q3.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
